mem_arbiter: RTL and testbench

- Arbitrates a single shared, single-port RAM between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sits between the pipeline and RAM. The data side (older instruction) has strict priority.
- While a data access owns the RAM, the block raises a fetch stall so the fetch stage holds its PC.
- Hardware counterpart of the execute stage's load/store stall request.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 75 +++++++
 rtl/mem_arb_watchdog.sv | 31 +++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the fetch/data RAM arbiter.
// Optional watchdog macro: MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int WD_W       = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_BUSY = 2'd1,
    IF_BUSY  = 2'd2
  } arb_state_e;

  function automatic logic is_busy(
    input arb_state_e s
  );
    return (s == MEM_BUSY) || (s == IF_BUSY);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and RAM-side signal bundle of the RAM arbiter.
// slave = arbiter view, master = pipeline/RAM view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              mem_readmem;
  logic              mem_writemem;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              if_stall;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;

  logic              arb_err;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_rdata,
    output if_ready,
    input  mem_readmem,
    input  mem_writemem,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready,
    output if_stall,
    output ram_addr,
    output ram_wdata,
    output ram_re,
    output ram_we,
    input  ram_rdata,
    input  ram_ready,
    output arb_err
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_rdata,
    input  if_ready,
    output mem_readmem,
    output mem_writemem,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready,
    input  if_stall,
    input  ram_addr,
    input  ram_wdata,
    input  ram_re,
    input  ram_we,
    output ram_rdata,
    output ram_ready,
    input  arb_err
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog; instantiated only when MEM_ARB_TIMEOUT_EN is defined.
// o_expire flags the last allowed busy cycle.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [WD_W-1:0] LP_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt >= LP_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data side beats fetch, fetch stalls meanwhile.
// Define MEM_ARB_TIMEOUT_EN to add the busy watchdog and arb_err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be in 2..255");
  end

  arb_state_e r_state;
  arb_state_e w_state_nx;

  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W-1:0] w_ram_addr_nx;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] w_ram_wdata_nx;
  logic              r_ram_re;
  logic              w_ram_re_nx;
  logic              r_ram_we;
  logic              w_ram_we_nx;

  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] w_if_rdata_nx;
  logic              r_if_ready;
  logic              w_if_ready_nx;
  logic [DATA_W-1:0] r_mem_rdata;
  logic [DATA_W-1:0] w_mem_rdata_nx;
  logic              r_mem_ready;
  logic              w_mem_ready_nx;
  logic              r_if_stall;
  logic              w_if_stall_nx;

  logic w_mem_req;
  logic w_expire;
  logic w_abort;
  logic w_done;
  logic [DATA_W-1:0] w_rd;

  assign w_mem_req = bus.mem_readmem | bus.mem_writemem;
  assign w_abort   = w_expire & ~bus.ram_ready;
  assign w_done    = bus.ram_ready | w_expire;
  assign w_rd      = w_abort ? '0 : bus.ram_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  logic r_arb_err;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clock),
    .rst_n    (reset),
    .i_clr    (r_state == IDLE),
    .i_en     (is_busy(r_state)),
    .o_expire (w_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_arb_err <= 1'b0;
    end else if (w_abort) begin
      r_arb_err <= 1'b1;
    end
  end

  assign bus.arb_err = r_arb_err;
`else
  assign w_expire    = 1'b0;
  assign bus.arb_err = 1'b0;
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_ram_addr_nx  = r_ram_addr;
    w_ram_wdata_nx = r_ram_wdata;
    w_ram_re_nx    = r_ram_re;
    w_ram_we_nx    = r_ram_we;
    w_if_rdata_nx  = r_if_rdata;
    w_mem_rdata_nx = r_mem_rdata;
    w_if_ready_nx  = 1'b0;
    w_mem_ready_nx = 1'b0;
    w_if_stall_nx  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_mem_req) begin
          // a combined read+write request is handled as a store
          w_state_nx     = MEM_BUSY;
          w_ram_addr_nx  = bus.mem_addr;
          w_ram_wdata_nx = bus.mem_wdata;
          w_ram_we_nx    = bus.mem_writemem;
          w_ram_re_nx    = ~bus.mem_writemem;
          w_if_stall_nx  = 1'b1;
        end else if (bus.if_req) begin
          w_state_nx     = IF_BUSY;
          w_ram_addr_nx  = bus.if_addr;
          w_ram_wdata_nx = '0;
          w_ram_re_nx    = 1'b1;
          w_ram_we_nx    = 1'b0;
        end
      end
      MEM_BUSY: begin
        w_if_stall_nx = 1'b1;
        if (w_done) begin
          w_state_nx     = IDLE;
          w_ram_re_nx    = 1'b0;
          w_ram_we_nx    = 1'b0;
          w_mem_ready_nx = 1'b1;
          if (!r_ram_we) begin
            w_mem_rdata_nx = w_rd;
          end
        end
      end
      IF_BUSY: begin
        if (w_done) begin
          w_state_nx    = IDLE;
          w_ram_re_nx   = 1'b0;
          w_ram_we_nx   = 1'b0;
          w_if_ready_nx = 1'b1;
          w_if_rdata_nx = w_rd;
        end
      end
      default: begin
        w_state_nx  = IDLE;
        w_ram_re_nx = 1'b0;
        w_ram_we_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_re    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_if_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_mem_rdata <= '0;
      r_mem_ready <= 1'b0;
      r_if_stall  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ram_addr  <= w_ram_addr_nx;
      r_ram_wdata <= w_ram_wdata_nx;
      r_ram_re    <= w_ram_re_nx;
      r_ram_we    <= w_ram_we_nx;
      r_if_rdata  <= w_if_rdata_nx;
      r_if_ready  <= w_if_ready_nx;
      r_mem_rdata <= w_mem_rdata_nx;
      r_mem_ready <= w_mem_ready_nx;
      r_if_stall  <= w_if_stall_nx;
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_re    = r_ram_re;
  assign bus.ram_we    = r_ram_we;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_ready = r_mem_ready;
  assign bus.if_stall  = r_if_stall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model plus directed scenarios.
// Define MEM_ARB_TIMEOUT_EN to also exercise the watchdog.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN      = 1'b1;
  localparam int TB_TIMEOUT = 4;
`else
  localparam bit TO_EN      = 1'b0;
  localparam int TB_TIMEOUT = 16;
`endif
  localparam logic [31:0] K = 32'h5A5A0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // RAM: word = addr ^ K, except the fetch test word at 0x100
  function automatic logic [31:0] ram_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'h2002000A : (a ^ K);
  endfunction

  int ram_lat  = 2;
  int ram_k    = 0;
  bit spurious = 1'b0;

  always @(negedge clock) begin
    if (bus.ram_re || bus.ram_we) ram_k++;
    else ram_k = 0;
    bus.ram_ready = ((ram_lat > 0) && (ram_k == ram_lat)) || spurious;
    bus.ram_rdata = ram_data(bus.ram_addr);
  end

  // requesters drop their request once they see their ready pulse
  int tot_if  = 0;
  int tot_mem = 0;
  always @(negedge clock) begin
    if (bus.if_ready) begin
      bus.if_req = 1'b0;
      tot_if++;
    end
    if (bus.mem_ready) begin
      bus.mem_readmem  = 1'b0;
      bus.mem_writemem = 1'b0;
      tot_mem++;
    end
  end

  // transaction-level model: who owns the RAM and for how many cycles
  int owner = 0;
  int busy  = 0;
  bit to;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_mem_rdata;
  bit e_re, e_we, e_if_ready, e_mem_ready, e_stall, e_err;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner = 0; busy = 0;
      e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_mem_rdata = 0;
      e_re = 0; e_we = 0; e_if_ready = 0; e_mem_ready = 0;
      e_stall = 0; e_err = 0;
    end else if (owner == 0) begin
      e_if_ready  = 0;
      e_mem_ready = 0;
      if (bus.mem_readmem || bus.mem_writemem) begin
        owner   = 1;
        e_addr  = bus.mem_addr;
        e_wdata = bus.mem_wdata;
        e_we    = bus.mem_writemem;
        e_re    = !bus.mem_writemem;
      end else if (bus.if_req) begin
        owner  = 2;
        e_addr = bus.if_addr;
        e_re   = 1;
        e_we   = 0;
      end
      busy    = 0;
      e_stall = (owner == 1);
    end else begin
      busy++;
      to = TO_EN && (busy >= TB_TIMEOUT) && !bus.ram_ready;
      if (bus.ram_ready || to) begin
        if (owner == 1) begin
          e_mem_ready = 1;
          if (!e_we) e_mem_rdata = to ? 32'h0 : bus.ram_rdata;
        end else begin
          e_if_ready = 1;
          e_if_rdata = to ? 32'h0 : bus.ram_rdata;
        end
        if (to) e_err = 1;
        owner = 0;
        e_re  = 0;
        e_we  = 0;
      end
    end
  end

  always @(negedge clock) begin
    chk("ram_re", bus.ram_re, e_re);
    chk("ram_we", bus.ram_we, e_we);
    if (e_re || e_we) chk("ram_addr", bus.ram_addr, e_addr);
    if (e_we) chk("ram_wdata", bus.ram_wdata, e_wdata);
    chk("if_ready", bus.if_ready, e_if_ready);
    chk("mem_ready", bus.mem_ready, e_mem_ready);
    chk("if_rdata", bus.if_rdata, e_if_rdata);
    chk("mem_rdata", bus.mem_rdata, e_mem_rdata);
    chk("if_stall", bus.if_stall, e_stall);
    chk("arb_err", bus.arb_err, e_err);
  end

  int n_re, n_we, n_stall, n_if, n_mem, t_if, t_mem, t_ifre;
  logic [31:0] last_addr, last_wdata, rd_if, rd_mem;

  task automatic wait_done(input bit need_if, input bit need_mem);
    int cyc;
    bit done;
    n_re = 0; n_we = 0; n_stall = 0; n_if = 0; n_mem = 0;
    t_if = 0; t_mem = 0; t_ifre = 0; cyc = 0; done = 0;
    while (!done && cyc < 64) begin
      @(negedge clock);
      cyc++;
      if (bus.ram_re) n_re++;
      if (bus.ram_we) begin
        n_we++;
        last_wdata = bus.ram_wdata;
      end
      if (bus.ram_re || bus.ram_we) last_addr = bus.ram_addr;
      if (bus.ram_re && bus.ram_addr == 32'h104 && t_ifre == 0) t_ifre = cyc;
      if (bus.if_stall) n_stall++;
      if (bus.if_ready) begin
        n_if++; t_if = cyc; rd_if = bus.if_rdata;
      end
      if (bus.mem_ready) begin
        n_mem++; t_mem = cyc; rd_mem = bus.mem_rdata;
      end
      done = (!need_if || n_if > 0) && (!need_mem || n_mem > 0);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done bound expired if=%0d mem=%0d", n_if, n_mem);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  int b_if, b_mem;

  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.mem_readmem = 0; bus.mem_writemem = 0;
    bus.mem_addr = 0; bus.mem_wdata = 0;
    bus.ram_rdata = 0; bus.ram_ready = 0;
    idle(3);
    chk("rst_ram_re", bus.ram_re, 0);
    chk("rst_if_stall", bus.if_stall, 0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    #2 reset = 1;
    idle(2);

    // fetch only, RAM answers after 3 strobe cycles
    ram_lat = 3;
    bus.if_addr = 32'h100; bus.if_req = 1;
    b_if = tot_if;
    wait_done(1, 0);
    chk("f_re_cycles", n_re, 3);
    chk("f_addr", last_addr, 32'h100);
    chk("f_rdata", rd_if, 32'h2002000A);
    chk("f_latency", t_if, 4);
    chk("f_stall", n_stall, 0);
    chk("model_if_rdata", e_if_rdata, 32'h2002000A);
    idle(3);
    chk("f_pulses", tot_if - b_if, 1);

    // simultaneous: data first, one idle cycle, then fetch
    ram_lat = 2;
    bus.if_addr = 32'h104; bus.if_req = 1;
    bus.mem_addr = 32'h400; bus.mem_readmem = 1;
    wait_done(1, 1);
    chk("s_mem_t", t_mem, 3);
    chk("s_mem_rdata", rd_mem, 32'h5A5A0400);
    chk("s_stall", n_stall, 3);
    chk("s_gap", t_ifre - t_mem, 1);
    chk("s_if_t", t_if, 6);
    chk("s_if_rdata", rd_if, 32'h5A5A0104);
    chk("model_mem_rdata", e_mem_rdata, 32'h5A5A0400);
    idle(2);

    // store leaves mem_rdata untouched
    bus.mem_addr = 32'h40; bus.mem_wdata = 32'hDEADBEEF;
    bus.mem_writemem = 1;
    wait_done(0, 1);
    chk("st_we", n_we, 2);
    chk("st_re", n_re, 0);
    chk("st_addr", last_addr, 32'h40);
    chk("st_wdata", last_wdata, 32'hDEADBEEF);
    chk("st_rdata", rd_mem, 32'h5A5A0400);
    idle(2);

    // read+write together counts as store; minimum 2-cycle latency
    ram_lat = 1;
    bus.mem_addr = 32'h44; bus.mem_wdata = 32'h12345678;
    bus.mem_readmem = 1; bus.mem_writemem = 1;
    wait_done(0, 1);
    chk("rw_we", n_we, 1);
    chk("rw_re", n_re, 0);
    chk("rw_wdata", last_wdata, 32'h12345678);
    chk("rw_lat", t_mem, 2);
    idle(2);

    // fetch dropped mid-access still completes
    ram_lat = 3;
    bus.if_addr = 32'h108; bus.if_req = 1;
    idle(1);
    bus.if_req = 0;
    wait_done(1, 0);
    chk("drop_rdata", rd_if, 32'h5A5A0108);
    idle(2);

    // ram_ready while idle is ignored
    b_if = tot_if; b_mem = tot_mem;
    @(posedge clock); #1 spurious = 1;
    @(posedge clock); #1 spurious = 0;
    idle(3);
    chk("spur_if", tot_if - b_if, 0);
    chk("spur_mem", tot_mem - b_mem, 0);

    // reset in the middle of a data access
    ram_lat = 0;
    b_mem = tot_mem;
    bus.mem_addr = 32'h200; bus.mem_readmem = 1;
    idle(2);
    chk("pre_rst_re", bus.ram_re, 1);
    @(posedge clock); #2 reset = 0;
    #1;
    chk("mid_rst_re", bus.ram_re, 0);
    chk("mid_rst_stall", bus.if_stall, 0);
    chk("mid_rst_mem_rdata", bus.mem_rdata, 0);
    chk("mid_rst_if_rdata", bus.if_rdata, 0);
    bus.mem_readmem = 0;
    @(negedge clock); #2 reset = 1;
    idle(3);
    chk("rst_no_pulse", tot_mem - b_mem, 0);
    ram_lat = 2;
    bus.if_addr = 32'h10C; bus.if_req = 1;
    wait_done(1, 0);
    chk("post_rst_t", t_if, 3);
    chk("post_rst_rdata", rd_if, 32'h5A5A010C);
    idle(2);

`ifdef MEM_ARB_TIMEOUT_EN
    ram_lat = 0;
    bus.mem_addr = 32'h80; bus.mem_readmem = 1;
    wait_done(0, 1);
    chk("to_re_cycles", n_re, 4);
    chk("to_t", t_mem, 5);
    chk("to_rdata", rd_mem, 0);
    idle(1);
    chk("to_err", bus.arb_err, 1);
    ram_lat = 2;
    bus.if_addr = 32'h104; bus.if_req = 1;
    wait_done(1, 0);
    chk("to_err_sticky", bus.arb_err, 1);
    idle(2);
    #1 reset = 0;
    #2 chk("to_err_rst", bus.arb_err, 0);
    @(negedge clock); #2 reset = 1;
    idle(2);
`else
    chk("no_wd_err", bus.arb_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
